// File: rtl/register_sequencer.sv
// register_sequencer: fetch/decode/exec/mem/wb control FSM for the 16-bit core.
// Define REGISTER_SEQUENCER_PERF_EN to add o_cycle_cnt / o_instr_cnt counters.
module register_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_rdata,
    input  logic [15:0] i_jmp_target,
    input  logic [15:0] i_ls_addr,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_ir,
    output logic [15:0] o_pc,
    output logic        o_ri,
    output logic        o_st,
    output logic        o_jmp,
    output logic        o_fn,
    output logic        o_wb_en,
    output logic        o_wb_sel,
    output logic [15:0] o_load_data,
    output logic        o_halted,
    output logic        o_bus_err,
    output logic        o_illegal
`ifdef REGISTER_SEQUENCER_PERF_EN
    ,
    output logic [31:0] o_cycle_cnt,
    output logic [31:0] o_instr_cnt
`endif
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_ALUI  = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_ls_addr;
    logic [15:0] r_load_data;
    logic [15:0] r_to_cnt;
    logic        r_bus_err;

    logic [3:0]  w_op;
    logic        w_is_store;
    logic        w_req;
    logic        w_ack;
    logic [15:0] w_to_inc;
    logic        w_timeout;

    // mem_req is decoded from state but forced low the instant reset rises
    assign w_op       = r_ir[3:0];
    assign w_is_store = (w_op == OP_STORE);
    assign w_req      = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_rst;
    assign w_ack      = w_req && i_mem_ack;
    assign w_to_inc   = r_to_cnt + 16'd1;
    assign w_timeout  = w_req && !i_mem_ack && (w_to_inc == TO_LIM);

    assign o_ir        = r_ir;
    assign o_pc        = r_pc;
    assign o_load_data = r_load_data;
    assign o_bus_err   = r_bus_err;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next state and strobes, decoded from state and ir only
    always_comb begin
        w_next     = r_state;
        o_mem_req  = w_req;
        o_mem_we   = 1'b0;
        o_mem_addr = r_pc;
        o_ri       = 1'b0;
        o_st       = 1'b0;
        o_jmp      = 1'b0;
        o_fn       = 1'b0;
        o_wb_en    = 1'b0;
        o_wb_sel   = 1'b0;
        o_halted   = 1'b0;
        o_illegal  = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (w_timeout)  w_next = S_HALT;
                else if (w_ack) w_next = S_DECODE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op)
                    OP_NOP: ;
                    OP_ALU: begin
                        o_fn    = 1'b1;
                        o_wb_en = 1'b1;
                    end
                    OP_ALUI: begin
                        o_fn    = 1'b1;
                        o_ri    = 1'b1;
                        o_wb_en = 1'b1;
                    end
                    OP_LOAD:  w_next = S_MEM;
                    OP_STORE: w_next = S_MEM;
                    OP_JMP:   o_jmp  = 1'b1;
                    OP_HALT:  w_next = S_HALT;
                    default:  o_illegal = 1'b1;
                endcase
            end
            S_MEM: begin
                o_mem_addr = r_ls_addr;
                o_mem_we   = w_is_store;
                o_st       = w_is_store;
                if (w_timeout)  w_next = S_HALT;
                else if (w_ack) w_next = w_is_store ? S_FETCH : S_WB;
            end
            S_WB: begin
                o_wb_en  = 1'b1;
                o_wb_sel = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: o_halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    // PC, IR, load data, latched address, bus timeout
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_ls_addr   <= '0;
            r_load_data <= '0;
            r_to_cnt    <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_req)
                r_to_cnt <= i_mem_ack ? 16'd0 : w_to_inc;
            if (w_timeout)
                r_bus_err <= 1'b1;
            if (r_state == S_FETCH && w_ack) begin
                r_ir <= i_mem_rdata;
                r_pc <= r_pc + 16'd1;
            end
            if (r_state == S_EXEC) begin
                r_ls_addr <= i_ls_addr;
                if (w_op == OP_JMP)
                    r_pc <= i_jmp_target;
            end
            if (r_state == S_MEM && w_ack && !w_is_store)
                r_load_data <= i_mem_rdata;
        end
    end

`ifdef REGISTER_SEQUENCER_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_instr_cnt = r_instr_cnt;

    // Free-running activity counters, frozen while halted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (r_state == S_EXEC) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_register_sequencer.sv
// tb_register_sequencer: instruction-level reference model feeding a scoreboard,
// plus directed timeout and mid-access reset scenarios.
module tb_register_sequencer;

    localparam int TO = 4;

    localparam int K_FE   = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_ALU  = 3;
    localparam int K_ALUI = 4;
    localparam int K_JMP  = 5;
    localparam int K_ILL  = 6;
    localparam int K_WBL  = 7;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        int          gap;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack = 1'b0;
    logic [15:0] rdata = 16'h0;
    logic [15:0] jt;
    logic [15:0] ls;
    logic        req, we, ri, st, jmp, fn, wb_en, wb_sel;
    logic        halted, bus_err, illegal;
    logic [15:0] addr, ir, pc, load_data;
`ifdef REGISTER_SEQUENCER_PERF_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif

    logic [15:0] mem [0:65535];
    ev_t         q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mode = 1;
    int          wait_left = 0;
    bit          active = 0;
    bit          sb_on = 0;
    bit          sb_done = 0;
    int          exp_end_ins = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] f_ls(input logic [15:0] w);
        return {w[15:4], 4'h0} ^ 16'h0040;
    endfunction

    function automatic logic [15:0] f_jt(input logic [15:0] w);
        return {w[15:4], 4'h0} ^ 16'h1234;
    endfunction

    assign ls = f_ls(ir);
    assign jt = f_jt(ir);

    register_sequencer #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_mem_ack(ack), .i_mem_rdata(rdata),
        .i_jmp_target(jt), .i_ls_addr(ls),
        .o_mem_req(req), .o_mem_we(we), .o_mem_addr(addr),
        .o_ir(ir), .o_pc(pc), .o_ri(ri), .o_st(st), .o_jmp(jmp), .o_fn(fn),
        .o_wb_en(wb_en), .o_wb_sel(wb_sel), .o_load_data(load_data),
        .o_halted(halted), .o_bus_err(bus_err), .o_illegal(illegal)
`ifdef REGISTER_SEQUENCER_PERF_EN
        , .o_cycle_cnt(cyc_cnt), .o_instr_cnt(ins_cnt)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] a,
                        input logic [15:0] d, input int g);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.gap = g;
        q.push_back(e);
    endtask

    // Instruction-level model: walks the program and lists the visible events.
    task automatic model(input int n, input bit timed);
        logic [15:0] p;
        logic [15:0] w;
        int          lat;
        bit          last_mem;
        q.delete();
        p = 16'h0000;
        lat = -1;
        last_mem = 0;
        for (int i = 0; i < n; i++) begin
            push(K_FE, p, 16'h0, timed ? lat : -1);
            w = mem[p];
            p = p + 16'd1;
            lat = 3;
            last_mem = 0;
            case (w[3:0])
                4'h0: ;
                4'h1: push(K_ALU, 16'h0, 16'h0, -1);
                4'h2: push(K_ALUI, 16'h0, 16'h0, -1);
                4'h3: begin
                    push(K_RD, f_ls(w), 16'h0, -1);
                    push(K_WBL, 16'h0, mem[f_ls(w)], -1);
                    lat = 5;
                    last_mem = 1;
                end
                4'h4: begin
                    push(K_WR, f_ls(w), 16'h0, -1);
                    lat = 4;
                    last_mem = 1;
                end
                4'h5: begin
                    push(K_JMP, 16'h0, 16'h0, -1);
                    p = f_jt(w);
                end
                default: push(K_ILL, 16'h0, 16'h0, -1);
            endcase
        end
        exp_end_ins = last_mem ? n : n - 1;
    endtask

    function automatic logic [5:0] exp_vec(input int k);
        case (k)
            K_ALU:   return 6'b100010;
            K_ALUI:  return 6'b110010;
            K_JMP:   return 6'b001000;
            K_ILL:   return 6'b000100;
            K_WBL:   return 6'b000011;
            default: return 6'b111111;
        endcase
    endfunction

    // Memory responder: random or zero wait states, stray acks when idle
    always @(negedge clk) begin
        if (mode == 2) begin
            ack = 1'b0;
        end else if (req) begin
            if (!active) begin
                active = 1;
                wait_left = (mode == 1) ? 0 : $urandom_range(0, TO - 1);
            end
            if (wait_left == 0) begin
                ack = 1'b1;
                rdata = mem[addr];
                active = 0;
            end else begin
                ack = 1'b0;
                rdata = 16'($urandom);
                wait_left--;
            end
        end else begin
            ack = 1'($urandom_range(0, 1));
            rdata = 16'($urandom);
            active = 0;
        end
    end

    // Monitor: pops the scoreboard on every bus completion or strobe cycle
    int          cyc = 0;
    int          last_fetch = -1;
    bit          pw = 0;
    logic [15:0] pa;
    logic        pwe;
    always @(negedge clk) begin
        ev_t e;
        #1;
        cyc++;
        if (rst) begin
            last_fetch = -1;
            pw = 0;
        end else if (sb_on && !sb_done) begin
            if (pw) begin
                check("hold_req", req, 1);
                check("hold_addr", addr, pa);
                check("hold_we", we, pwe);
            end
            pw = req && !ack;
            pa = addr;
            pwe = we;
            check("st_vs_we", st, req && we);
            if (req && ack && q.size() > 0) begin
                e = q.pop_front();
                check("bus_we", we, (e.kind == K_WR) ? 1 :
                      ((e.kind == K_FE || e.kind == K_RD) ? 0 : 2));
                check("bus_addr", addr, e.addr);
                if (e.kind == K_FE) begin
                    check("fetch_pc", pc, e.addr);
                    if (e.gap >= 0)
                        check("latency", cyc - last_fetch, e.gap);
                    last_fetch = cyc;
                end
            end
            if ((fn | ri | jmp | illegal | wb_en | wb_sel) && q.size() > 0) begin
                e = q.pop_front();
                check("strobes", {fn, ri, jmp, illegal, wb_en, wb_sel},
                      exp_vec(e.kind));
                if (e.kind == K_WBL)
                    check("load_data", load_data, e.data);
            end
            if (q.size() == 0) begin
                sb_done = 1;
`ifdef REGISTER_SEQUENCER_PERF_EN
                check("instr_cnt", ins_cnt, exp_end_ins);
`endif
            end
        end
    end

    initial begin
        bit found;
`ifdef REGISTER_SEQUENCER_PERF_EN
        logic [31:0] c0;
`endif
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", req, 0);
        check("rst_pc", pc, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_flags", {halted, bus_err, illegal, st, we}, 0);
        check("rst_strobes", {fn, ri, jmp, wb_en, wb_sel}, 0);
        check("rst_load_data", load_data, 16'h0000);
`ifdef REGISTER_SEQUENCER_PERF_EN
        check("rst_perf", {cyc_cnt, ins_cnt} != 64'h0, 0);
`endif

        mem[16'h0000] = 16'h0021;
        mem[16'h0001] = 16'h0003;
        mem[16'h0040] = 16'hBEEF;
        mem[16'h0002] = 16'h00C4;
        mem[16'h0003] = 16'h0007;
        mem[16'h0004] = 16'h0012;
        mem[16'h0005] = 16'h0005;
        mem[16'h1234] = 16'hEDC5;
        for (int a = 16'hFFF4; a <= 16'hFFFF; a++) mem[a] = 16'h0001;
        model(21, 1);
        mode = 1;
        sb_done = 0;
        sb_on = 1;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 2000 && !sb_done; i++) @(posedge clk);
        check("drain_directed", sb_done, 1);
        sb_on = 0;

        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 65536; i++) begin
            logic [31:0] r;
            r = $urandom();
            mem[i] = {r[15:4], 4'($urandom_range(0, 14))};
        end
        model(300, 0);
        mode = 0;
        sb_done = 0;
        sb_on = 1;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 30000 && !sb_done; i++) @(posedge clk);
        check("drain_random", sb_done, 1);
        sb_on = 0;

        rst = 1'b1;
        mode = 2;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        check("to_early_err", bus_err, 0);
        check("to_early_req", req, 1);
        @(posedge clk);
        #1;
        check("to_bus_err", bus_err, 1);
        check("to_halted", halted, 1);
        check("to_req", req, 0);
`ifdef REGISTER_SEQUENCER_PERF_EN
        c0 = cyc_cnt;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("to_sticky", {bus_err, halted, req}, 3'b110);
`ifdef REGISTER_SEQUENCER_PERF_EN
        check("cycle_frozen", cyc_cnt, c0);
`endif

        rst = 1'b1;
        #1;
        check("rst_clears_err", {bus_err, halted}, 0);
        mem[16'h0000] = 16'h0003;
        mode = 1;
        @(posedge clk);
        #2 rst = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (req && addr == 16'h0040) found = 1;
        end
        check("mem_reached", found, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_req", req, 0);
        check("abort_pc", pc, 16'h0000);
        check("abort_ir", ir, 16'h0000);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2;
        check("restart_req", req, 1);
        check("restart_addr", addr, 16'h0000);
        check("restart_load", load_data, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_sequencer.md
Name: register_sequencer

Overview:
- Multi-cycle control FSM that sequences the register fetch unit and register file for the 16-bit core.
- Fetches instructions over a req/ack memory port, decodes the opcode and drives the RFU control strobes `ri`, `st`, `jmp` and `fn`.
- Sequences load/store memory accesses and the register write-back, and owns the PC.
- Sits between instruction/data memory and the RFU; the RFU consumes `ir` fields [7:4], [11:8] and [15:12] directly.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT, 255, max cycles `mem_req` may wait for `mem_ack` before a bus error (1..65535).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_ack  in  1  memory completes the current access this cycle
- mem_rdata  in  16  read data, valid when `mem_ack`=1
- jmp_target  in  16  jump destination from the RFU `a` output
- ls_addr  in  16  load/store address from the RFU `b` output
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (store), 0 = read
- mem_addr  out  16  access address
- ir  out  16  current instruction register
- pc  out  16  program counter
- ri, st, jmp, fn  out  1 each  RFU control strobes
- wb_en  out  1  register write-back strobe
- wb_sel  out  1  write-back source: 0 = ALU, 1 = load data
- load_data  out  16  latched load result
- halted  out  1  core halted
- bus_err  out  1  sticky memory-timeout flag
- illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (asynchronous): state=FETCH, pc=RESET_PC, timeout counter=0. All other outputs and registers are 0: ir, load_data, every strobe, halted, bus_err, illegal.
- Opcode is ir[3:0]:
  - 0x0 NOP
  - 0x1 ALU reg-reg
  - 0x2 ALU reg-imm
  - 0x3 LOAD
  - 0x4 STORE
  - 0x5 JMP
  - 0xF HALT
  - 0x6–0xE illegal; execute as NOP and assert `illegal` during EXEC.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are registered or decoded from state and ir only; no input-to-output combinational paths.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On a clock edge with mem_ack=1: ir<=mem_rdata, pc<=pc+1 (wraps 16'hFFFF→0), go to DECODE.
- DECODE: one cycle, no strobes, go to EXEC.
- EXEC, exactly one cycle, by opcode:
  - ALU reg-reg: fn=1, wb_en=1, wb_sel=0, then FETCH.
  - ALU reg-imm: additionally ri=1.
  - JMP: jmp=1, pc<=jmp_target at the end of the cycle, then FETCH.
  - LOAD/STORE: go to MEM.
  - NOP/illegal: go to FETCH.
  - HALT: go to HALT.
- MEM:
  - mem_req=1, mem_addr=ls_addr; mem_we=1 and st=1 for STORE, held until ack.
  - On ack: STORE goes to FETCH; LOAD latches load_data<=mem_rdata and goes to WB.
- WB: wb_en=1, wb_sel=1 for one cycle, then FETCH.
- HALT: halted=1, no requests; left only by reset.
- Handshake:
  - mem_ack is sampled only when mem_req=1; an ack while mem_req=0 is ignored.
  - Ack may arrive in the first request cycle (zero wait).
  - mem_req and mem_addr stay stable until the ack.
- Timeout:
  - Counter increments each cycle that mem_req=1 and mem_ack=0; it clears on ack.
  - When the counter reaches TIMEOUT: bus_err<=1 (sticky) and go to HALT.
- Latency, with zero-wait memory: NOP/ALU/JMP take 3 cycles; STORE takes 4; LOAD takes 5.
- Reset asserted in any state aborts the operation immediately; mem_req drops asynchronously.

Optional Feature:
- Macro: REGISTER_SEQUENCER_PERF_EN.
- When defined, adds two 32-bit outputs:
  - cycle_cnt: increments every non-halted cycle.
  - instr_cnt: increments on each EXEC cycle.
  - Both reset to 0 and wrap on overflow.
- When undefined, neither port nor any counter logic exists.

Test Plan:
- Reset, then memory returns 16'h0021 (ALU reg-imm) with zero wait → mem_addr=0 in cycle 1; EXEC in cycle 3 with fn=1, ri=1, wb_en=1, wb_sel=0; pc=1.
- LOAD 16'h0003, ls_addr=16'h0040, data ack after 2 wait cycles with 16'hBEEF → mem_we=0, mem_addr=16'h0040 held 3 cycles; load_data=16'hBEEF; WB asserts wb_en=1, wb_sel=1.
- STORE 16'h0004, ls_addr=16'h0080 → mem_we=1 and st=1 held until ack; no wb_en; next FETCH at pc+1.
- JMP 16'h0005 with jmp_target=16'h1234 → jmp=1 for one cycle; next mem_addr=16'h1234. Separately, pc=16'hFFFF fetch → pc wraps to 0.
- Fetch with mem_ack held 0 and TIMEOUT=4 → after 4 waiting cycles bus_err=1, halted=1, mem_req=0. Opcode 16'h0007 → illegal pulses 1 cycle, then the next fetch occurs.
- Assert rst mid-MEM → mem_req=0 immediately; pc=RESET_PC; after release the fetch restarts at 0. With REGISTER_SEQUENCER_PERF_EN, instr_cnt=3 after three completed instructions.
